rr_bus_arbiter: RTL

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/rr_bus_arbiter.sv | 64 ++++++
 1 files changed

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin 4-way bus arbiter with burst limit and a registered output slot
module rr_bus_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [15:0] data3,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic [3:0]  ack,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t state, state_next;
    logic [1:0] ptr, pick;
    logic [3:0] count, owner_mask;
    logic [15:0] bus;
    logic xfer, others, burst_end;
    always_comb begin
        owner_mask = 4'b0001 << sel;
        busy = state == OWN;
        grant = busy ? owner_mask : 4'b0000;
        xfer = !reset && busy && req[sel] && (!out_valid || out_ready);
        ack = xfer ? owner_mask : 4'b0000;
        others = |(req & ~owner_mask);
        burst_end = xfer && (count + 4'd1 == 4'(MAX_BURST));
        bus = sel == 2'd0 ? data0 : sel == 2'd1 ? data1 : sel == 2'd2 ? data2 : data3;
        state_next = busy ? ((!req[sel] || (burst_end && others)) ? IDLE : OWN)
                          : (|req ? OWN : IDLE);
        // Descending scan so the nearest requester after ptr wins; ptr itself is last.
        pick = ptr;
        for (int k = 4; k >= 1; k--)
            if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    end
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_next;
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 2'd3;
            count <= 4'd0;
            sel <= 2'd0;
            out_data <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            if (!busy && |req) sel <= pick;
            if (busy && state_next == IDLE) begin
                ptr <= sel;
                count <= 4'd0;
            end else if (xfer) count <= burst_end ? 4'd0 : count + 4'd1;
            if (xfer) begin
                out_data <= bus;
                out_valid <= 1'b1;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule
